// File: rtl/operand_gen.sv
// Operand-pair stimulus generator: two 32-bit Galois LFSRs feed A/B over a valid/ready handshake,
// NUM_OPS pairs per start request. Define OPERAND_GEN_CORNER_EN to prefix each burst with corner pairs.
module operand_gen #(
   parameter int          WIDTH   = 32,
   parameter int          NUM_OPS = 16,
   parameter logic [31:0] SEED_A  = 32'h0000_0001,
   parameter logic [31:0] SEED_B  = 32'h0000_ACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             done,
   output logic [31:0]      count
);

   localparam logic [31:0] POLY       = 32'h8020_0003;
   localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
   localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DONE} state_e;

   state_e           state_q;
   logic [31:0]      lfsr_a_q, lfsr_b_q, lfsr_a_d, lfsr_b_d;
   logic [31:0]      count_q, count_d;
   logic [WIDTH-1:0] a_q, b_q, a_d, b_d, a_start, b_start;
   logic             valid_q, busy_q, done_q;
   logic             last_xfer;

   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      return (r >> 1) ^ (r[0] ? POLY : 32'd0);
   endfunction

`ifdef OPERAND_GEN_CORNER_EN
   localparam logic [31:0] N_CORNER = 32'd4;

   function automatic logic [2*WIDTH-1:0] corner_pair(input logic [1:0] idx);
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] one;
      logic [WIDTH-1:0] msb;
      ones = '1;
      one  = WIDTH'(1);
      msb  = one << (WIDTH - 1);
      case (idx)
         2'd0:    return '0;
         2'd1:    return {ones, one};
         2'd2:    return {ones, ones};
         default: return {msb, msb};
      endcase
   endfunction
`endif

   always_comb begin
      count_d   = count_q + 32'd1;
      last_xfer = (count_d == 32'(NUM_OPS));
`ifdef OPERAND_GEN_CORNER_EN
      // Corner pairs occupy the first slots of the burst; LFSRs advance only past LFSR pairs.
      lfsr_a_d = (count_q >= N_CORNER) ? lfsr_step(lfsr_a_q) : lfsr_a_q;
      lfsr_b_d = (count_q >= N_CORNER) ? lfsr_step(lfsr_b_q) : lfsr_b_q;
      if (count_d < N_CORNER) begin
         {a_d, b_d} = corner_pair(count_d[1:0]);
      end else begin
         {a_d, b_d} = {lfsr_a_d[WIDTH-1:0], lfsr_b_d[WIDTH-1:0]};
      end
      {a_start, b_start} = corner_pair(2'd0);
`else
      lfsr_a_d = lfsr_step(lfsr_a_q);
      lfsr_b_d = lfsr_step(lfsr_b_q);
      a_d      = lfsr_a_d[WIDTH-1:0];
      b_d      = lfsr_b_d[WIDTH-1:0];
      a_start  = SEED_A_EFF[WIDTH-1:0];
      b_start  = SEED_B_EFF[WIDTH-1:0];
`endif
   end

   // NOTE: reset is synchronous (checked inside the clocked block) and all state uses <= only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         lfsr_a_q <= SEED_A_EFF;
         lfsr_b_q <= SEED_B_EFF;
         count_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q  <= S_PRESENT;
                  lfsr_a_q <= SEED_A_EFF;
                  lfsr_b_q <= SEED_B_EFF;
                  count_q  <= '0;
                  a_q      <= a_start;
                  b_q      <= b_start;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
               end
            end
            S_PRESENT: begin
               // valid is always high here, so ready alone marks a transfer.
               if (ready) begin
                  count_q  <= count_d;
                  lfsr_a_q <= lfsr_a_d;
                  lfsr_b_q <= lfsr_b_d;
                  if (last_xfer) begin
                     state_q <= S_DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     a_q <= a_d;
                     b_q <= b_d;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign A     = a_q;
   assign B     = b_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign count = count_q;

endmodule

// File: tb/tb_operand_gen.sv
// Scoreboard bench for operand_gen (WIDTH=8): stimulus queues expected pairs, a negedge monitor
// pops and compares on every accepted transfer.
module tb_operand_gen;

   localparam int W = 8;
`ifdef OPERAND_GEN_CORNER_EN
   localparam int N = 6;
`else
   localparam int N = 3;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic [W-1:0]  a, b;
   logic          valid, busy, done;
   logic [31:0]   count;

   int            checks = 0;
   int            failures = 0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] seq[N];

   always #5 clk = ~clk;

   operand_gen #(.WIDTH(W), .NUM_OPS(N), .SEED_A(32'h0000_0001), .SEED_B(32'h0000_ACE1)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .valid(valid),
      .ready(ready), .busy(busy), .done(done), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst();
      for (int i = 0; i < N; i++) exp_q.push_back(seq[i]);
   endtask

   // Monitor: an accepted transfer is valid && ready on a cycle not being reset.
   always @(negedge clk) begin
      if (rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_transfer", {16'h0, a, b}, 32'hFFFF_FFFF);
         end else begin
            check("pair", {16'h0, a, b}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
`ifdef OPERAND_GEN_CORNER_EN
      seq = '{16'h0000, 16'hFF01, 16'hFFFF, 16'h8080, 16'h01E1, 16'h0373};
`else
      seq = '{16'h01E1, 16'h0373, 16'h023A};
`endif

      // Reset state
      tick(); tick();
      check("rst_valid", valid, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      rst = 1'b1;
      tick();

      // Basic burst with ready held high
      push_burst();
      start = 1'b1; ready = 1'b1;
      tick();
      start = 1'b0;
      check("start_valid", valid, 1);
      check("start_busy", busy, 1);
      repeat (N) tick();
      check("burst_done", done, 1);
      check("burst_count", count, N);
      check("burst_valid_low", valid, 0);
      check("burst_busy_low", busy, 0);

      // Re-arm from DONE under backpressure
      push_burst();
      ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("rearm_count", count, 0);
      check("rearm_done", done, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_pair", {16'h0, a, b}, {16'h0, seq[0]});
         check("bp_count", count, 0);
         check("bp_valid", valid, 1);
      end
      ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         tick();
         check("xfer_count", count, i + 1);
      end
      check("rearm_burst_done", done, 1);
      tick(); tick();
      check("ready_idle_count", count, N);
      check("ready_idle_valid", valid, 0);

      // Mid-burst start is ignored, mid-burst reset drops valid
      push_burst();
      ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; ready = 1'b1;
      tick();
      ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("midstart_count", count, 1);
      check("midstart_pair", {16'h0, a, b}, {16'h0, seq[1]});
      check("midstart_busy", busy, 1);
      ready = 1'b1;
      tick();
      check("mid_count2", count, 2);
      rst = 1'b0;
      tick();
      check("midrst_valid", valid, 0);
      check("midrst_count", count, 0);
      exp_q.delete();
      rst = 1'b1;

      // Fresh burst after reset restarts from the first pair
      push_burst();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_first_pair", {16'h0, a, b}, {16'h0, seq[0]});
      begin
         int cyc = 0;
         while (!done && cyc < 50) begin
            tick();
            cyc++;
         end
      end
      check("restart_done", done, 1);
      check("restart_count", count, N);
      tick(); tick();
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_gen.md
# operand_gen

Upstream stimulus stage for the adder DUT. Produces a pseudo-random stream of operand pairs (A, B) from two independent LFSRs and delivers them over the DUT's input valid/ready handshake, one pair per accepted transfer. Runs a burst of NUM_OPS pairs per start request, then reports completion. The pair count and completion flag let the bench close a run.

## Interface
- WIDTH, 32: operand width in bits; legal range 1..32.
- NUM_OPS, 16: pairs per burst; must be ≥1.
- SEED_A, 32'h0000_0001: LFSR-A seed; a value of 0 is replaced by 1.
- SEED_B, 32'h0000_ACE1: LFSR-B seed; a value of 0 is replaced by 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- start  in  1  one-cycle burst request; sampled only in IDLE and DONE.
- A  out  WIDTH  operand A.
- B  out  WIDTH  operand B.
- valid  out  1  A and B hold a pair offered to the DUT.
- ready  in  1  DUT accepts the pair.
- busy  out  1  high in PRESENT.
- done  out  1  high in DONE.
- count  out  32  number of pairs accepted in the current burst.

## Operation
- Reset (rst==0 at an edge) forces state=IDLE, valid=0, busy=0, done=0, count=0, A=0, B=0, LFSR-A=SEED_A, and LFSR-B=SEED_B, with zero-seed substitution applied to both LFSRs.
- Each LFSR is a 32-bit Galois register: next = (r>>1) ^ (r[0] ? 32'h8020_0003 : 0). A = LFSR-A[WIDTH-1:0] and B = LFSR-B[WIDTH-1:0].
- States:
  - IDLE: when start=1, reload both seeds, clear count, and go to PRESENT.
  - PRESENT: valid=1. A transfer occurs on a cycle with valid && ready. On a transfer, count increments and both LFSRs step. If the new count equals NUM_OPS, go to DONE; otherwise stay in PRESENT.
  - DONE: valid=0 and done=1. When start=1, reload both seeds, clear count, and go to PRESENT.
- Stability: while valid && !ready, A and B must not change.
- start while in PRESENT is ignored.
- ready while valid=0 is ignored and causes no count change.
- Wrap: LFSR-truncated values may repeat within a burst; this is legal. count saturates at NUM_OPS.

## Timing
- start at edge N: valid=1 from edge N, carrying the first pair (the seeds truncated to WIDTH).
- Transfer at edge M, not the last of the burst: the next pair appears on A/B at edge M and valid stays high. Throughput is one pair per cycle if ready is held high.
- Last transfer at edge M: valid=0, busy=0, done=1, and count=NUM_OPS, all from edge M.
- Reset mid-burst: valid drops at the reset edge. Any pair offered on that cycle is not counted.

## Configuration
- OPERAND_GEN_CORNER_EN defined: each burst first issues the corner pairs, in order, before any LFSR pairs:
  - (0, 0)
  - (all-ones, 1)
  - (all-ones, all-ones)
  - (MSB-only, MSB-only)
- Corner pairs count toward NUM_OPS. If NUM_OPS < 4, only the first NUM_OPS corner pairs are issued.
- The LFSRs step only on transfers of LFSR pairs, so the first LFSR pair is always the seeds.
- OPERAND_GEN_CORNER_EN undefined: no corner logic; every pair comes from the LFSRs.

## Test plan
- Reset values: rst=0 for 2 cycles → valid=0, done=0, busy=0, count=0, A=0, B=0.
- Basic burst, macro off: WIDTH=8, NUM_OPS=3, ready held at 1, pulse start. Required response:
  - Pairs are (0x01,0xE1), (0x03,0x73), then the third LFSR pair.
  - done=1 the cycle after the 3rd transfer; count=3.
- Backpressure: hold ready=0 for 5 cycles during PRESENT → A/B unchanged, count unchanged, valid=1. Raise ready → exactly one transfer per cycle.
- Mid-burst start and reset: start pulsed in PRESENT → ignored, count continues. rst=0 mid-burst → valid=0 next edge. A new start → first pair again (0x01,0xE1).
- Corner mode: OPERAND_GEN_CORNER_EN, WIDTH=8, NUM_OPS=6. Pairs must be, in order:
  - (0x00,0x00), (0xFF,0x01), (0xFF,0xFF), (0x80,0x80) — the four corner pairs.
  - (0x01,0xE1), (0x03,0x73) — the first two LFSR pairs.
- Re-arm: start in DONE → count=0, done=0, and the burst repeats an identical sequence.
